// File: rtl/imager_pkg.sv
// Shared types and elaboration helpers for the imager front-end parser.
// Holds the parser state encoding and the parameter legality check.
package imager_pkg;

  typedef enum logic [2:0] {
    ST_X_LOW  = 3'd0,
    ST_X_HIGH = 3'd1,
    ST_Y_LOW  = 3'd2,
    ST_Y_HIGH = 3'd3,
    ST_PIXELS = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam int MAX_COORD_BYTES = 4;
  localparam int MAX_CH          = 4;

  function automatic int coord_w(input int bytes);
    return 8 * bytes;
  endfunction

  function automatic bit params_ok(
    input int cr,
    input int sp,
    input int cb,
    input int nc
  );
    return (cr >= 2) && (cr <= 16) &&
           (sp >= 0) && (sp < cr) &&
           (cb >= 1) && (cb <= MAX_COORD_BYTES) &&
           (nc >= 1) && (nc <= MAX_CH);
  endfunction

endpackage

// File: rtl/imager_byte_slot.sv
// Free-running byte-slot timer; strobes once per slot at the sample phase.
// The timer is never realigned by the frame qualifier.
module imager_byte_slot
  import imager_pkg::*;
#(
  parameter int CLK_RATIO    = 8,
  parameter int SAMPLE_PHASE = 1,
  localparam int TW = (CLK_RATIO > 2) ? $clog2(CLK_RATIO) : 1
) (
  input  logic clk_in,
  input  logic rst_n,
  output logic strobe
);

  logic [TW-1:0] timer;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (timer == TW'(CLK_RATIO - 1)) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  assign strobe = (timer == TW'(SAMPLE_PHASE));

endmodule

// File: rtl/imager_parser_gen2.sv
// Imager byte-stream parser: header capture, pixel assembly, x/y tagging.
// Header is four little-endian coordinates, then NUM_CH bytes per pixel.
module imager_parser_gen2
  import imager_pkg::*;
#(
  parameter int CLK_RATIO    = 8,
  parameter int SAMPLE_PHASE = 1,
  parameter int COORD_BYTES  = 4,
  parameter int NUM_CH       = 3,
  localparam int COORD_W = coord_w(COORD_BYTES),
  localparam int PIX_W   = 8 * NUM_CH
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               pxq,
  input  logic [7:0]         d_in,
  output logic [PIX_W-1:0]   pix_data,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [COORD_W-1:0] line_width,
  output logic [COORD_W-1:0] pic_height,
  output logic               dimensions_valid,
  output logic               hdr_err,
  output logic               frame_done
);

  if (!params_ok(CLK_RATIO, SAMPLE_PHASE, COORD_BYTES, NUM_CH)) begin : g_bad_params
    $error("imager_parser_gen2: illegal parameter set");
  end

  state_t state;
  state_t state_nxt;

  logic               slot_strobe;
  logic               sample;
  logic [1:0]         byte_idx;
  logic [1:0]         ch;
  logic               hdr_full;
  logic [COORD_W-1:0] x_low;
  logic [COORD_W-1:0] x_high;
  logic [COORD_W-1:0] y_low;
  logic [COORD_W-1:0] y_high;
  logic [COORD_W-1:0] cur;
  logic [COORD_W-1:0] ins;
  logic               is_hdr;
  logic               byte_last;
  logic               ch_last;
  logic               x_last;
  logic               y_last;
  logic               bad;

  imager_byte_slot #(
    .CLK_RATIO   (CLK_RATIO),
    .SAMPLE_PHASE(SAMPLE_PHASE)
  ) u_slot (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .strobe(slot_strobe)
  );

  assign sample    = slot_strobe & pxq;
  assign byte_last = (byte_idx == 2'(COORD_BYTES - 1));
  assign ch_last   = (ch == 2'(NUM_CH - 1));
  assign x_last    = (pix_x == line_width - COORD_W'(1));
  assign y_last    = (pix_y == pic_height - COORD_W'(1));
  assign bad       = (x_high <= x_low) || (y_high <= y_low);
  assign is_hdr    = (state == ST_X_LOW) || (state == ST_X_HIGH) ||
                     (state == ST_Y_LOW) || (state == ST_Y_HIGH);

  // Current coordinate with the incoming byte merged in at byte_idx.
  always_comb begin
    cur = x_low;
    unique case (state)
      ST_X_HIGH: cur = x_high;
      ST_Y_LOW:  cur = y_low;
      ST_Y_HIGH: cur = y_high;
      default:   cur = x_low;
    endcase
    ins = cur;
    for (int b = 0; b < COORD_BYTES; b++) begin
      if (byte_idx == 2'(b)) ins[8*b +: 8] = d_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= ST_X_LOW;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!pxq) begin
      state_nxt = ST_X_LOW;
    end else begin
      unique case (state)
        ST_X_LOW:  if (sample && byte_last) state_nxt = ST_X_HIGH;
        ST_X_HIGH: if (sample && byte_last) state_nxt = ST_Y_LOW;
        ST_Y_LOW:  if (sample && byte_last) state_nxt = ST_Y_HIGH;
        ST_Y_HIGH: if (hdr_full) state_nxt = bad ? ST_ERR : ST_PIXELS;
        ST_PIXELS: begin
          if (sample && ch_last && x_last && y_last) state_nxt = ST_DONE;
        end
        default:   state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx         <= '0;
      ch               <= '0;
      hdr_full         <= 1'b0;
      x_low            <= '0;
      x_high           <= '0;
      y_low            <= '0;
      y_high           <= '0;
      line_width       <= '0;
      pic_height       <= '0;
      pix_data         <= '0;
      pix_valid        <= 1'b0;
      pix_x            <= '0;
      pix_y            <= '0;
      dimensions_valid <= 1'b0;
      hdr_err          <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (!pxq) begin
        byte_idx         <= '0;
        ch               <= '0;
        hdr_full         <= 1'b0;
        pix_x            <= '0;
        pix_y            <= '0;
        dimensions_valid <= 1'b0;
        hdr_err          <= 1'b0;
      end else begin
        if (sample && is_hdr) begin
          unique case (state)
            ST_X_HIGH: x_high <= ins;
            ST_Y_LOW:  y_low  <= ins;
            ST_Y_HIGH: y_high <= ins;
            default:   x_low  <= ins;
          endcase
          byte_idx <= byte_last ? 2'd0 : byte_idx + 2'd1;
          if (state == ST_Y_HIGH && byte_last) begin
            hdr_full   <= 1'b1;
            line_width <= x_high - x_low;
            pic_height <= ins - y_low;
          end
        end
        // Validation runs one edge after y_high is complete.
        if (state == ST_Y_HIGH && hdr_full) begin
          hdr_full <= 1'b0;
          if (bad) hdr_err <= 1'b1;
          else     dimensions_valid <= 1'b1;
        end
        if (sample && state == ST_PIXELS) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (ch == 2'(k)) pix_data[8*k +: 8] <= d_in;
          end
          ch <= ch_last ? 2'd0 : ch + 2'd1;
          if (ch_last) begin
            pix_valid  <= 1'b1;
            frame_done <= x_last && y_last;
          end
        end
        // Position advances after the pulse so pix_x/pix_y tag the pixel.
        if (pix_valid && !frame_done) begin
          if (x_last) begin
            pix_x <= '0;
            pix_y <= pix_y + COORD_W'(1);
          end else begin
            pix_x <= pix_x + COORD_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imager_parser_gen2.sv
// Bench for imager_parser_gen2: header table plus scoreboarded pixel stream.
// Corner cases: aborts, trailing bytes, async reset mid-frame.
module tb_imager_parser_gen2;

  localparam int CW = 16;
  localparam int PW = 24;

  logic          clk_in = 1'b0;
  logic          rst_n  = 1'b0;
  logic          pxq    = 1'b0;
  logic [7:0]    d_in   = 8'h00;
  logic [PW-1:0] pix_data;
  logic          pix_valid;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic [CW-1:0] line_width;
  logic [CW-1:0] pic_height;
  logic          dimensions_valid;
  logic          hdr_err;
  logic          frame_done;

  int errors = 0;
  int checks = 0;
  int tmr;

  typedef struct {
    logic [PW-1:0] d;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          done;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [CW-1:0] xl;
    logic [CW-1:0] xh;
    logic [CW-1:0] yl;
    logic [CW-1:0] yh;
    logic [CW-1:0] lw;
    logic [CW-1:0] ph;
    logic          err;
  } hdr_vec_t;

  hdr_vec_t vecs[6];

  imager_parser_gen2 #(
    .CLK_RATIO   (8),
    .SAMPLE_PHASE(1),
    .COORD_BYTES (2),
    .NUM_CH      (3)
  ) dut (
    .clk_in          (clk_in),
    .rst_n           (rst_n),
    .pxq             (pxq),
    .d_in            (d_in),
    .pix_data        (pix_data),
    .pix_valid       (pix_valid),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .line_width      (line_width),
    .pic_height      (pic_height),
    .dimensions_valid(dimensions_valid),
    .hdr_err         (hdr_err),
    .frame_done      (frame_done)
  );

  always #5 clk_in = ~clk_in;

  // Independent slot timer: DUT samples on the posedge where tmr==1.
  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) tmr <= 0;
    else        tmr <= (tmr == 7) ? 0 : tmr + 1;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (rst_n && pix_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pix: got pix_valid at (%0d,%0d) expected none",
                 pix_x, pix_y);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pix_data", 64'(pix_data), 64'(e.d));
        chk("pix_x", 64'(pix_x), 64'(e.x));
        chk("pix_y", 64'(pix_y), 64'(e.y));
        chk("frame_done", 64'(frame_done), 64'(e.done));
      end
    end
    if (rst_n && frame_done && !pix_valid) begin
      checks++;
      errors++;
      $display("FAIL lone_frame_done: got frame_done=1 expected pix_valid=1");
    end
  end

  task automatic send_byte(input logic [7:0] b);
    do @(negedge clk_in); while (tmr != 1);
    d_in = b;
    @(posedge clk_in);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send_header(input logic [CW-1:0] xl, input logic [CW-1:0] xh,
                             input logic [CW-1:0] yl, input logic [CW-1:0] yh);
    send_byte(xl[7:0]); send_byte(xl[15:8]);
    send_byte(xh[7:0]); send_byte(xh[15:8]);
    send_byte(yl[7:0]); send_byte(yl[15:8]);
    send_byte(yh[7:0]); send_byte(yh[15:8]);
  endtask

  // Byte k carries k+1; expectation pushed just before a pixel's last byte.
  task automatic send_pixels(input int n, input int lw, input int ph);
    logic [PW-1:0] acc;
    exp_t e;
    int i;
    int c;
    acc = '0;
    for (int k = 0; k < n; k++) begin
      i = k / 3;
      c = k % 3;
      acc[8*c +: 8] = 8'(k + 1);
      if (c == 2 && i < lw * ph) begin
        e.d    = acc;
        e.x    = CW'(i % lw);
        e.y    = CW'(i / lw);
        e.done = (i == lw * ph - 1);
        sb.push_back(e);
      end
      send_byte(8'(k + 1));
    end
  endtask

  task automatic drop_pxq();
    wait_n(4);
    pxq = 1'b0;
    wait_n(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0002, 16'h0005, 16'h0001, 16'h0003, 16'd3, 16'd2, 1'b0};
    vecs[1] = '{16'h0004, 16'h0004, 16'h0001, 16'h0003, 16'd0, 16'd2, 1'b1};
    vecs[2] = '{16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'd1, 16'd1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0003, 16'h0000, 16'h0002, 16'hFFFE, 16'd2, 1'b1};
    vecs[4] = '{16'h0000, 16'h0002, 16'h0003, 16'h0003, 16'd2, 16'd0, 1'b1};
    vecs[5] = '{16'h0100, 16'h0102, 16'h00FF, 16'h0101, 16'd2, 16'd2, 1'b0};

    #23;
    chk("rst_pix_valid", 64'(pix_valid), 0);
    chk("rst_dims", 64'(dimensions_valid), 0);
    chk("rst_lw", 64'(line_width), 0);
    chk("rst_pix_data", 64'(pix_data), 0);
    @(negedge clk_in);
    rst_n = 1'b1;

    // Header table: good headers stream a frame, bad ones get junk bytes.
    for (int v = 0; v < 6; v++) begin
      pxq = 1'b1;
      send_header(vecs[v].xl, vecs[v].xh, vecs[v].yl, vecs[v].yh);
      wait_n(3);
      chk($sformatf("v%0d_lw", v), 64'(line_width), 64'(vecs[v].lw));
      chk($sformatf("v%0d_ph", v), 64'(pic_height), 64'(vecs[v].ph));
      chk($sformatf("v%0d_dims", v), 64'(dimensions_valid), 64'(!vecs[v].err));
      chk($sformatf("v%0d_err", v), 64'(hdr_err), 64'(vecs[v].err));
      if (vecs[v].err) begin
        send_pixels(6, 0, 0);
        wait_n(2);
        chk($sformatf("v%0d_err_hold", v), 64'(hdr_err), 1);
      end else begin
        send_pixels(3 * int'(vecs[v].lw) * int'(vecs[v].ph),
                    int'(vecs[v].lw), int'(vecs[v].ph));
      end
      wait_n(4);
      chk($sformatf("v%0d_sb_empty", v), 64'(sb.size()), 0);
      drop_pxq();
      chk($sformatf("v%0d_dims_clr", v), 64'(dimensions_valid), 0);
      chk($sformatf("v%0d_err_clr", v), 64'(hdr_err), 0);
    end

    // Mid-header abort after three bytes, then a full frame.
    pxq = 1'b1;
    send_byte(8'h77); send_byte(8'h77); send_byte(8'h77);
    drop_pxq();
    pxq = 1'b1;
    send_header(16'h0002, 16'h0005, 16'h0001, 16'h0003);
    wait_n(3);
    chk("hdr_abort_lw", 64'(line_width), 3);
    chk("hdr_abort_ph", 64'(pic_height), 2);
    send_pixels(18, 3, 2);
    wait_n(4);
    chk("hdr_abort_sb", 64'(sb.size()), 0);
    drop_pxq();

    // Mid-pixel abort: three pixels plus two channels of the fourth.
    pxq = 1'b1;
    send_header(16'h0002, 16'h0005, 16'h0001, 16'h0003);
    send_pixels(11, 3, 2);
    drop_pxq();
    chk("pix_abort_dims", 64'(dimensions_valid), 0);
    chk("pix_abort_sb", 64'(sb.size()), 0);
    pxq = 1'b1;
    send_header(16'h0002, 16'h0005, 16'h0001, 16'h0003);
    send_pixels(18, 3, 2);
    wait_n(4);
    chk("pix_abort_next_sb", 64'(sb.size()), 0);
    drop_pxq();

    // Six trailing bytes after frame_done are ignored.
    pxq = 1'b1;
    send_header(16'h0002, 16'h0005, 16'h0001, 16'h0003);
    send_pixels(24, 3, 2);
    wait_n(4);
    chk("extra_sb", 64'(sb.size()), 0);
    chk("extra_dims_hold", 64'(dimensions_valid), 1);
    drop_pxq();

    // Async reset between edges while in PIXELS.
    pxq = 1'b1;
    send_header(16'h0002, 16'h0005, 16'h0001, 16'h0003);
    send_pixels(5, 3, 2);
    wait_n(4);
    @(posedge clk_in);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pix_valid", 64'(pix_valid), 0);
    chk("arst_dims", 64'(dimensions_valid), 0);
    chk("arst_lw", 64'(line_width), 0);
    chk("arst_ph", 64'(pic_height), 0);
    chk("arst_xy", 64'({pix_x, pix_y}), 0);
    chk("arst_data", 64'(pix_data), 0);
    chk("arst_err_done", 64'({hdr_err, frame_done}), 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    send_header(16'h0002, 16'h0005, 16'h0001, 16'h0003);
    wait_n(3);
    chk("post_rst_dims", 64'(dimensions_valid), 1);
    send_pixels(18, 3, 2);
    wait_n(4);
    chk("post_rst_sb", 64'(sb.size()), 0);
    drop_pxq();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
